// File: rtl/pwr_domain_seq.sv
// pwr_domain_seq
// Power-up / power-down sequencer for one switchable voltage island.
// Staggers the power-switch segment enables, waits for the domain power-good,
// then orders clock enable, reset release and isolation release. Power-down
// runs the same steps in reverse. Lives in the always-on domain and talks to
// the SoC power controller over a 4-phase request/acknowledge pair.
//
// Ports:
//   clk_i      always-on clock
//   rst_i      synchronous reset, active-high
//   pwr_req_i  1 = domain wanted on, 0 = off (level)
//   pwr_ack_o  1 once ON is reached, 0 once OFF is reached, held in between
//   pgood_i    asynchronous power-good from the domain
//   sw_en_o    power-switch segment enables, thermometer-coded from bit 0
//   iso_en_o   isolation enable for the boundary cells (1 = clamped)
//   dom_rst_o  domain reset, active-high
//   clk_en_o   domain clock-gate enable
//   err_o      power-good timeout flag
//   state_o    current state encoding, for debug
module pwr_domain_seq #(
  parameter int SW_STAGES     = 4,
  parameter int STAGE_DLY     = 8,
  parameter int ISO_DLY       = 2,
  parameter int PGOOD_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pwr_req_i,
  output logic                 pwr_ack_o,
  input  logic                 pgood_i,
  output logic [SW_STAGES-1:0] sw_en_o,
  output logic                 iso_en_o,
  output logic                 dom_rst_o,
  output logic                 clk_en_o,
  output logic                 err_o,
  output logic [3:0]           state_o
);

  localparam int MAX_AB  = (STAGE_DLY > ISO_DLY) ? STAGE_DLY : ISO_DLY;
  localparam int MAX_DLY = (MAX_AB > PGOOD_TIMEOUT) ? MAX_AB : PGOOD_TIMEOUT;
  localparam int CW      = $clog2(MAX_DLY) + 1;

  // Counter reload values: a step fires on the cycle the counter is zero,
  // so a load of N-1 gives exactly N cycles in the current step.
  localparam logic [CW-1:0] STAGE_LD = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0] ISO_LD   = CW'(ISO_DLY - 1);
  localparam logic [CW-1:0] PG_LD    = CW'(PGOOD_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_OFF     = 4'd0,
    S_SW_UP   = 4'd1,
    S_PG_WAIT = 4'd2,
    S_CLK_ON  = 4'd3,
    S_RST_REL = 4'd4,
    S_ON      = 4'd5,
    S_ISO_SET = 4'd6,
    S_CLK_OFF = 4'd7,
    S_SW_DN   = 4'd8,
    S_ERR     = 4'd9
  } state_t;

  state_t                 state;
  logic   [CW-1:0]        cnt;
  logic                   cnt_zero;
  logic                   pg_meta;
  logic                   pg_sync;
  logic   [SW_STAGES-1:0] sw_more;
  logic   [SW_STAGES-1:0] sw_less;

  assign state_o  = state;
  assign cnt_zero = (cnt == '0);

  // Segments are always enabled contiguously from bit 0, so adding the next
  // segment is a shift-in of a one and dropping the highest is a shift right.
  assign sw_more = (sw_en_o << 1) | SW_STAGES'(1);
  assign sw_less = sw_en_o >> 1;

  // Power-good synchroniser. It is held cleared outside PG_WAIT so that a
  // power-good level left over from before the switches settled is never
  // taken as valid; the full two-flop latency is always paid after entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state != S_PG_WAIT)) begin
      pg_meta <= 1'b0;
      pg_sync <= 1'b0;
    end else begin
      pg_meta <= pgood_i;
      pg_sync <= pg_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_OFF;
      sw_en_o   <= '0;
      iso_en_o  <= 1'b1;
      dom_rst_o <= 1'b1;
      clk_en_o  <= 1'b0;
      pwr_ack_o <= 1'b0;
      err_o     <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        S_OFF: begin
          if (pwr_req_i) begin
            state   <= S_SW_UP;
            sw_en_o <= SW_STAGES'(1);
            err_o   <= 1'b0;
            cnt     <= STAGE_LD;
          end
        end

        S_SW_UP: begin
          if (!pwr_req_i) begin
            state   <= S_SW_DN;
            sw_en_o <= sw_less;
            cnt     <= STAGE_LD;
          end else if (cnt_zero) begin
            if (sw_en_o[SW_STAGES-1]) begin
              state <= S_PG_WAIT;
              cnt   <= PG_LD;
            end else begin
              sw_en_o <= sw_more;
              cnt     <= STAGE_LD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_PG_WAIT: begin
          if (!pwr_req_i) begin
            state   <= S_SW_DN;
            sw_en_o <= sw_less;
            cnt     <= STAGE_LD;
          end else if (pg_sync) begin
            state    <= S_CLK_ON;
            clk_en_o <= 1'b1;
            cnt      <= ISO_LD;
          end else if (cnt_zero) begin
            state     <= S_ERR;
            sw_en_o   <= '0;
            iso_en_o  <= 1'b1;
            dom_rst_o <= 1'b1;
            clk_en_o  <= 1'b0;
            err_o     <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_CLK_ON: begin
          if (!pwr_req_i) begin
            state     <= S_CLK_OFF;
            dom_rst_o <= 1'b1;
            clk_en_o  <= 1'b0;
            cnt       <= ISO_LD;
          end else if (cnt_zero) begin
            state     <= S_RST_REL;
            dom_rst_o <= 1'b0;
            cnt       <= ISO_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_RST_REL: begin
          if (!pwr_req_i) begin
            state     <= S_CLK_OFF;
            dom_rst_o <= 1'b1;
            clk_en_o  <= 1'b0;
            cnt       <= ISO_LD;
          end else if (cnt_zero) begin
            state     <= S_ON;
            iso_en_o  <= 1'b0;
            pwr_ack_o <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_ON: begin
          if (!pwr_req_i) begin
            state    <= S_ISO_SET;
            iso_en_o <= 1'b1;
            cnt      <= ISO_LD;
          end
        end

        S_ISO_SET: begin
          if (cnt_zero) begin
            state     <= S_CLK_OFF;
            dom_rst_o <= 1'b1;
            clk_en_o  <= 1'b0;
            cnt       <= ISO_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_CLK_OFF: begin
          if (cnt_zero) begin
            state   <= S_SW_DN;
            sw_en_o <= sw_less;
            cnt     <= STAGE_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_SW_DN: begin
          if (sw_en_o == '0) begin
            state     <= S_OFF;
            pwr_ack_o <= 1'b0;
            cnt       <= '0;
          end else if (cnt_zero) begin
            sw_en_o <= sw_less;
            cnt     <= STAGE_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_ERR: begin
          if (!pwr_req_i) begin
            state     <= S_OFF;
            pwr_ack_o <= 1'b0;
            cnt       <= '0;
          end
        end

        default: begin
          state     <= S_OFF;
          sw_en_o   <= '0;
          iso_en_o  <= 1'b1;
          dom_rst_o <= 1'b1;
          clk_en_o  <= 1'b0;
          pwr_ack_o <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule
